// File: rtl/pattern_capture.sv
// pattern_capture: records {timestamp, bin, dec, hex} whenever the monitored
// fields change while capture is enabled, buffering records in a
// first-word-fall-through FIFO with drop counting on overflow.
module pattern_capture #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [3:0]      bin_in,
  input  logic [31:0]     dec_in,
  input  logic [31:0]     hex_in,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [TS_W-1:0] rec_time,
  output logic [3:0]      rec_bin,
  output logic [31:0]     rec_dec,
  output logic [31:0]     rec_hex,
  output logic [15:0]     overflow_cnt,
  output logic            ts_wrap
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [TS_W-1:0]    time_cnt;
  logic [67:0]        prev;
  logic [TS_W+67:0]   mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;

  logic [67:0]        cur;
  logic [TS_W-1:0]    push_ts;
  logic               push;
  logic               pop;
  logic               empty;
  logic               full;
  logic               wr_en;
  logic               drop;

  assign cur = {bin_in, dec_in, hex_in};

  // Decide whether this edge produces a record and whether the FIFO accepts it.
  // The first enabled edge of a window always records (timestamp 0); later
  // edges record only on a change. A full FIFO still accepts when popping.
  always_comb begin
    push    = en && ((state == IDLE) || (cur != prev));
    push_ts = (state == IDLE) ? '0 : time_cnt;
    empty   = (count == '0);
    full    = (count == FULL_CNT);
    pop     = !empty && rec_ready;
    wr_en   = push && (!full || pop);
    drop    = push && full && !pop;
  end

  // Capture controller: arms on en, tracks previous sample and timestamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      time_cnt <= '0;
      prev     <= '0;
      ts_wrap  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            prev     <= cur;
            time_cnt <= TS_W'(1);
            state    <= RUN;
          end
        end
        RUN: begin
          if (en) begin
            prev     <= cur;
            time_cnt <= time_cnt + TS_W'(1);
            if (&time_cnt) ts_wrap <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && (overflow_cnt != 16'hFFFF)) overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  // Record storage; contents are qualified by occupancy so need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {push_ts, cur};
  end

  assign rec_valid = !empty;
  assign {rec_time, rec_bin, rec_dec, rec_hex} = mem[rd_ptr];

endmodule

// File: tb/tb_pattern_capture.sv
// Bench for pattern_capture: a default-width instance and a TS_W=4 instance
// share stimulus; a queue-based model predicts the record stream for both.
module tb_pattern_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  bin_in;
  logic [31:0] dec_in;
  logic [31:0] hex_in;
  logic        rec_ready;

  logic        o_valid, o_wrap;
  logic [31:0] o_time, o_dec, o_hex;
  logic [3:0]  o_bin;
  logic [15:0] o_ovf;

  logic        o4_valid, o4_wrap;
  logic [3:0]  o4_time, o4_bin;
  logic [31:0] o4_dec, o4_hex;
  logic [15:0] o4_ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pattern_capture dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bin_in(bin_in), .dec_in(dec_in),
    .hex_in(hex_in), .rec_valid(o_valid), .rec_ready(rec_ready),
    .rec_time(o_time), .rec_bin(o_bin), .rec_dec(o_dec), .rec_hex(o_hex),
    .overflow_cnt(o_ovf), .ts_wrap(o_wrap)
  );

  pattern_capture #(.DEPTH(8), .TS_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .bin_in(bin_in), .dec_in(dec_in),
    .hex_in(hex_in), .rec_valid(o4_valid), .rec_ready(rec_ready),
    .rec_time(o4_time), .rec_bin(o4_bin), .rec_dec(o4_dec), .rec_hex(o4_hex),
    .overflow_cnt(o4_ovf), .ts_wrap(o4_wrap)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a record list, an armed flag for the enable window and the
  // window's enabled-edge count; 4-bit timestamps are the low bits.
  typedef struct packed {
    logic [31:0] ts;
    logic [3:0]  b;
    logic [31:0] d;
    logic [31:0] h;
  } rec_t;

  rec_t        q[$];
  rec_t        mrec;
  bit          armed;
  logic [31:0] tc;
  logic [67:0] mprev, mcur;
  int          m_ovf;
  bit          m_wrap4;
  bit          do_pop, do_push;
  int          size0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      armed = 0; tc = 0; mprev = '0; m_ovf = 0; m_wrap4 = 0;
    end else begin
      mcur    = {bin_in, dec_in, hex_in};
      size0   = q.size();
      do_pop  = (size0 > 0) && rec_ready;
      do_push = 0;
      if (en) begin
        if (!armed) begin
          mrec = {32'd0, mcur}; do_push = 1; tc = 1; armed = 1;
        end else begin
          if (mcur != mprev) begin mrec = {tc, mcur}; do_push = 1; end
          if (tc % 16 == 15) m_wrap4 = 1;
          tc = tc + 1;
        end
        mprev = mcur;
      end else begin
        armed = 0;
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        if (size0 < 8 || do_pop) q.push_back(mrec);
        else if (m_ovf < 65535) m_ovf++;
      end
    end
  end

  // Compare both instances against the model every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", o_valid, q.size() != 0);
      check("valid4", o4_valid, q.size() != 0);
      if (q.size() != 0) begin
        check("rec", {o_time, o_bin, o_dec, o_hex}, q[0]);
        check("rec4", {o4_time, o4_bin, o4_dec, o4_hex}, {q[0].ts[3:0], q[0].b, q[0].d, q[0].h});
      end
      check("ovf", o_ovf, m_ovf);
      check("ovf4", o4_ovf, m_ovf);
      check("wrap", o_wrap, 1'b0);
      check("wrap4", o4_wrap, m_wrap4);
    end
  end

  task automatic step(input logic e, input logic [3:0] b, input logic [31:0] d,
                      input logic [31:0] h, input logic r);
    en = e; bin_in = b; dec_in = d; hex_in = h; rec_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; bin_in = '0; dec_in = '0; hex_in = '0; rec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_ovf", o_ovf, 16'd0);
    check("rst_wrap", o_wrap, 1'b0);
    rst_n = 1'b1;

    // First enabled edge records ts=0; static inputs record nothing more.
    step(1, 4'b0011, 32'd5, 32'h00AB, 1);
    check("first_rec", {o_valid, o_time, o_bin, o_dec, o_hex}, {1'b1, 32'd0, 4'b0011, 32'd5, 32'h00AB});
    step(1, 4'b0011, 32'd5, 32'h00AB, 1);
    step(1, 4'b0011, 32'd5, 32'h00AB, 1);
    check("static_none", o_valid, 1'b0);
    step(1, 4'b0011, 32'd7, 32'h00AB, 1);
    check("change_rec", {o_valid, o_time, o_dec}, {1'b1, 32'd3, 32'd7});
    repeat (3) step(1, 4'b0011, 32'd7, 32'h00AB, 1);
    check("after_change_none", o_valid, 1'b0);
    step(0, 4'b0011, 32'd7, 32'h00AB, 1);

    // Twelve changing edges with no consumer: 8 kept, 4 dropped.
    for (int i = 0; i < 12; i++) step(1, i[3:0], 32'd100 + i, i, 0);
    check("ovf_after_12", o_ovf, 16'd4);
    check("head_ts0", {o_valid, o_time, o_dec}, {1'b1, 32'd0, 32'd100});
    for (int k = 0; k < 8; k++) begin
      step(0, 4'd0, 32'd0, 32'd0, 1);
      if (k < 7) check("drain_ts", o_time, k + 1);
      else check("drain_empty", o_valid, 1'b0);
    end

    // Full FIFO: push and pop together keep occupancy; the next push drops.
    for (int i = 0; i < 8; i++) step(1, 4'd0, 32'd200 + i, 32'd0, 0);
    check("full_ovf", o_ovf, 16'd4);
    step(1, 4'd0, 32'd300, 32'd0, 1);
    check("full_pushpop_ovf", o_ovf, 16'd4);
    check("full_pushpop_head", o_time, 32'd1);
    step(1, 4'd0, 32'd301, 32'd0, 0);
    check("still_full_drop", o_ovf, 16'd5);
    repeat (10) step(0, 4'd0, 32'd0, 32'd0, 1);
    check("drained", o_valid, 1'b0);

    // 4-bit timestamps wrap after the 16th enabled edge.
    for (int j = 1; j <= 18; j++) begin
      step(1, j[3:0], 32'd400 + j, 32'd0, 1);
      check("ts4", o4_time, (j - 1) % 16);
      check("ts32", o_time, j - 1);
      check("wrap4_flag", o4_wrap, j >= 16);
    end
    repeat (2) step(0, 4'd0, 32'd0, 32'd0, 1);

    // Reset in the middle of a backlog discards it at once.
    for (int i = 0; i < 3; i++) step(1, 4'd0, 32'd500 + i, 32'd0, 0);
    check("backlog", o_valid, 1'b1);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", o_valid, 1'b0);
    check("rst_mid_valid4", o4_valid, 1'b0);
    check("rst_mid_ovf", o_ovf, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 4'd0, 32'd600, 32'd0, 1);
    check("post_rst_rec", {o_valid, o_time, o_dec}, {1'b1, 32'd0, 32'd600});
    repeat (2) step(0, 4'd0, 32'd0, 32'd0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
